// File: rtl/mmse_pkg.sv
// Shared types and constants for the 4x4 Gauss-Seidel MMSE solver.
// Q16.16 data words, Q32.32 accumulator, fixed 64-cycle divide.
package mmse_pkg;

  localparam int N       = 4;
  localparam int WIDTH   = 32;
  localparam int FRAC    = 16;
  localparam int DIV_CYC = 64;

  typedef logic signed [WIDTH-1:0]   fx_t;
  typedef logic signed [2*WIDTH-1:0] acc_t;

  typedef enum logic [2:0] {
    IDLE,
    MAC,
    DIV,
    WB,
    DONE
  } state_t;

endpackage

// File: rtl/gs_divider.sv
// Signed restoring divider, one quotient bit per cycle; done pulses 64 cycles after start.
// No backpressure: a new start restarts it, reset aborts it.
module gs_divider
  import mmse_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  acc_t dividend,
  input  fx_t  divisor,
  output logic done,
  output fx_t  quotient,
  output logic overflow
);

  logic        busy_q, busy_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        neg_q, neg_d;
  logic        done_q, done_d;
  logic [63:0] dvd_q, dvd_d;
  logic [31:0] dvs_q, dvs_d;
  logic [31:0] rem_q, rem_d;

  logic [63:0] dvd_abs, src_dvd;
  logic [31:0] dvs_abs, src_dvs, src_rem, rem_nxt;
  logic [32:0] shifted, diff;
  logic        qbit;

  // The start cycle already performs the first iteration on the live operands,
  // so 64 edges complete all 64 quotient bits.
  always_comb begin
    dvd_abs = dividend[63] ? $unsigned(-dividend) : $unsigned(dividend);
    dvs_abs = divisor[31] ? $unsigned(-divisor) : $unsigned(divisor);
    src_dvd = start ? dvd_abs : dvd_q;
    src_dvs = start ? dvs_abs : dvs_q;
    src_rem = start ? 32'd0 : rem_q;
    shifted = {src_rem, src_dvd[63]};
    diff    = shifted - {1'b0, src_dvs};
    qbit    = ~diff[32];
    rem_nxt = qbit ? diff[31:0] : shifted[31:0];

    busy_d = busy_q;
    cnt_d  = cnt_q;
    neg_d  = neg_q;
    dvd_d  = dvd_q;
    dvs_d  = dvs_q;
    rem_d  = rem_q;
    done_d = 1'b0;

    if (start) begin
      busy_d = 1'b1;
      cnt_d  = 6'd1;
      neg_d  = dividend[63] ^ divisor[31];
      dvs_d  = src_dvs;
      rem_d  = rem_nxt;
      dvd_d  = {src_dvd[62:0], qbit};
    end else if (busy_q) begin
      cnt_d = cnt_q + 6'd1;
      rem_d = rem_nxt;
      dvd_d = {src_dvd[62:0], qbit};
      if (cnt_q == 6'(DIV_CYC - 1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_comb begin
    overflow = neg_q ? (dvd_q > 64'h0000_0000_8000_0000)
                     : (dvd_q > 64'h0000_0000_7FFF_FFFF);
    if (overflow) begin
      quotient = neg_q ? fx_t'(32'h8000_0000) : fx_t'(32'h7FFF_FFFF);
    end else begin
      quotient = neg_q ? fx_t'(-dvd_q[31:0]) : fx_t'(dvd_q[31:0]);
    end
  end

  assign done = done_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      neg_q  <= 1'b0;
      done_q <= 1'b0;
      dvd_q  <= '0;
      dvs_q  <= '0;
      rem_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      neg_q  <= neg_d;
      done_q <= done_d;
      dvd_q  <= dvd_d;
      dvs_q  <= dvs_d;
      rem_q  <= rem_d;
    end
  end

endmodule

// File: rtl/gs_mmse_solver.sv
// Gauss-Seidel solver for A*x=b (4x4, Q16.16); fixed 276*ITERS cycles from accept to out_valid.
// in_ready only in IDLE; results held in DONE until out_ready.
module gs_mmse_solver
  import mmse_pkg::*;
#(
  parameter int ITERS = 3
)
(
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [0:N-1][0:N-1][WIDTH-1:0]   matrix_A,
  input  logic [0:N-1][WIDTH-1:0]          vector_b,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [0:N-1][WIDTH-1:0]          x_hat,
  output logic                             singular,
  output logic                             sat
);

  state_t                           state_q, state_d;
  logic [0:N-1][0:N-1][WIDTH-1:0]   a_q, a_d;
  logic [0:N-1][WIDTH-1:0]          b_q, b_d;
  logic [0:N-1][WIDTH-1:0]          x_q, x_d;
  logic [0:N-1][WIDTH-1:0]          x_hat_q, x_hat_d;
  acc_t                             acc_q, acc_d;
  logic [1:0]                       row_q, row_d;
  logic [1:0]                       col_q, col_d;
  logic [2:0]                       sweep_q, sweep_d;
  logic [5:0]                       div_cnt_q, div_cnt_d;
  logic                             singular_q, singular_d;
  logic                             sat_q, sat_d;
  logic                             out_valid_q, out_valid_d;

  fx_t  a_sel, x_sel, pivot, div_quot, wb_val;
  acc_t product, term, b_ext;
  logic div_start, div_done, div_ovf, quot_take;

  gs_divider u_div (
    .clk      (clk),
    .reset    (reset),
    .start    (div_start),
    .dividend (acc_q),
    .divisor  (pivot),
    .done     (div_done),
    .quotient (div_quot),
    .overflow (div_ovf)
  );

  // One shared multiplier: the operand pair is picked by the current row/column.
  always_comb begin
    a_sel     = a_q[row_q][col_q];
    x_sel     = x_q[col_q];
    pivot     = a_q[row_q][row_q];
    product   = acc_t'(a_sel) * acc_t'(x_sel);
    term      = (col_q == row_q) ? '0 : product;
    b_ext     = acc_t'(fx_t'(b_q[row_q])) <<< FRAC;
    quot_take = div_done && (pivot != '0);
    wb_val    = quot_take ? div_quot : '0;
  end

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    x_d         = x_q;
    x_hat_d     = x_hat_q;
    acc_d       = acc_q;
    row_d       = row_q;
    col_d       = col_q;
    sweep_d     = sweep_q;
    div_cnt_d   = div_cnt_q;
    singular_d  = singular_q;
    sat_d       = sat_q;
    out_valid_d = out_valid_q;
    div_start   = 1'b0;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d        = matrix_A;
          b_d        = vector_b;
          x_d        = '0;
          acc_d      = '0;
          row_d      = '0;
          col_d      = '0;
          sweep_d    = '0;
          singular_d = 1'b0;
          sat_d      = 1'b0;
          state_d    = MAC;
        end
      end
      MAC: begin
        acc_d = ((col_q == 2'd0) ? b_ext : acc_q) - term;
        col_d = col_q + 2'd1;
        if (col_q == 2'(N - 1)) begin
          div_cnt_d = '0;
          state_d   = DIV;
        end
      end
      DIV: begin
        div_start = (div_cnt_q == 6'd0);
        div_cnt_d = div_cnt_q + 6'd1;
        if (div_cnt_q == 6'(DIV_CYC - 1)) begin
          state_d = WB;
        end
      end
      WB: begin
        x_d[row_q] = wb_val;
        singular_d = singular_q | (pivot == '0);
        sat_d      = sat_q | (quot_take && div_ovf);
        col_d      = '0;
        if (row_q != 2'(N - 1)) begin
          row_d   = row_q + 2'd1;
          state_d = MAC;
        end else if (sweep_q != 3'(ITERS - 1)) begin
          sweep_d = sweep_q + 3'd1;
          row_d   = '0;
          state_d = MAC;
        end else begin
          x_hat_d     = x_d;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign x_hat     = x_hat_q;
  assign singular  = singular_q;
  assign sat       = sat_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      x_q         <= '0;
      x_hat_q     <= '0;
      acc_q       <= '0;
      row_q       <= '0;
      col_q       <= '0;
      sweep_q     <= '0;
      div_cnt_q   <= '0;
      singular_q  <= 1'b0;
      sat_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      x_q         <= x_d;
      x_hat_q     <= x_hat_d;
      acc_q       <= acc_d;
      row_q       <= row_d;
      col_q       <= col_d;
      sweep_q     <= sweep_d;
      div_cnt_q   <= div_cnt_d;
      singular_q  <= singular_d;
      sat_q       <= sat_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule
